// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end.
// Holds the fetch FSM encoding, the NOP word and the default reset PC.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;

  localparam logic [31:0] MIPS_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] MIPS_RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/Next_PC_Logic.sv
// Next-PC select: jump > taken branch > sequential PC + 4.
// Ports: PCPlus4, InstrIndex (Instr[25:0]), SignImm, Jump, PCSrc -> NextPC.
module Next_PC_Logic (
  input  logic [31:0] PCPlus4,
  input  logic [25:0] InstrIndex,
  input  logic [31:0] SignImm,
  input  logic        Jump,
  input  logic        PCSrc,
  output logic [31:0] NextPC
);

  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] target;

  assign jump_target   = {PCPlus4[31:28], InstrIndex, 2'b00};
  assign branch_target = PCPlus4 + (SignImm << 2);

  always_comb begin
    target = PCPlus4;
    if (Jump) begin
      target = jump_target;
    end else if (PCSrc) begin
      target = branch_target;
    end
  end

  // Keep every fetch address word aligned.
  assign NextPC = {target[31:2], 2'b00};

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: IDLE -> FETCH -> ISSUE loop with PC register.
// Ports: CLK, RST(n), PCSrc, Jump, SignImm, Stall, IMemAck, IMemRData ->
//        IMemReq, IMemAddr, Instr, InstrValid, PC, PCPlus4.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = MIPS_RESET_PC,
  parameter logic [31:0] NOP_INSTR = MIPS_NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PCSrc,
  input  logic        Jump,
  input  logic [31:0] SignImm,
  input  logic        Stall,
  input  logic        IMemAck,
  input  logic [31:0] IMemRData,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4
);

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  fetch_state_e state;
  fetch_state_e state_next;
  logic [31:0]  next_pc;

  Next_PC_Logic u_next_pc (
    .PCPlus4    (PCPlus4),
    .InstrIndex (Instr[25:0]),
    .SignImm    (SignImm),
    .Jump       (Jump),
    .PCSrc      (PCSrc),
    .NextPC     (next_pc)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    IMemReq    = 1'b0;
    unique case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        IMemReq = 1'b1;
        if (IMemAck) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!Stall) begin
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Acks outside FETCH fall through with no effect on PC or Instr.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      PC         <= RESET_PC_AL;
      Instr      <= NOP_INSTR;
      InstrValid <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (IMemAck) begin
            Instr      <= IMemRData;
            InstrValid <= 1'b1;
          end
        end
        ISSUE: begin
          if (!Stall) begin
            PC         <= next_pc;
            Instr      <= NOP_INSTR;
            InstrValid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign IMemAddr = PC;
  assign PCPlus4  = PC + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed corner cases, then random
// traffic checked against a program-level model of the fetch stream.
module tb_instr_fetch;
  import mips_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        PCSrc = 1'b0;
  logic        Jump = 1'b0;
  logic [31:0] SignImm = '0;
  logic        Stall = 1'b0;
  logic        IMemAck = 1'b0;
  logic [31:0] IMemRData;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:0] junk = 32'hDEAD_BEEF;

  always #5 CLK = ~CLK;

  instr_fetch dut (
    .CLK        (CLK),
    .RST        (RST),
    .PCSrc      (PCSrc),
    .Jump       (Jump),
    .SignImm    (SignImm),
    .Stall      (Stall),
    .IMemAck    (IMemAck),
    .IMemRData  (IMemRData),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .PC         (PC),
    .PCPlus4    (PCPlus4)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h20) return 32'h0800_0040;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] pc,
                                           input logic [31:0] ins,
                                           input logic j,
                                           input logic b,
                                           input logic [31:0] imm);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (j) return {seq[31:28], ins[25:0], 2'b00};
    if (b) return seq + imm * 32'd4;
    return seq;
  endfunction

  assign IMemRData = IMemReq ? mem_word(IMemAddr) : junk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic advance(input logic j, input logic b,
                         input logic [31:0] imm);
    model_pc = ref_next(model_pc, mem_word(model_pc), j, b, imm);
    sbq.push_back('{model_pc, mem_word(model_pc)});
  endtask

  // Monitor: compares each newly issued instruction against the queue.
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;
  logic        stall_edge;

  always @(posedge CLK) begin
    exp_t e;
    stall_edge = Stall;
    #1;
    if (RST) begin
      if (InstrValid && !prev_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got issue pc %h expected none", PC);
        end else begin
          e = sbq.pop_front();
          check("issue_pc", PC, e.pc);
          check("issue_instr", Instr, e.instr);
          check("issue_pcplus4", PCPlus4, e.pc + 32'd4);
        end
      end
      if (prev_valid && stall_edge) begin
        check("stall_valid", {31'd0, InstrValid}, 32'd1);
        check("stall_pc", PC, prev_pc);
        check("stall_instr", Instr, prev_instr);
        check("stall_req", {31'd0, IMemReq}, 32'd0);
      end
      if (prev_valid && !stall_edge) begin
        check("retire_valid", {31'd0, InstrValid}, 32'd0);
        check("retire_nop", Instr, MIPS_NOP_INSTR);
      end
      if (IMemReq) check("req_addr", IMemAddr, PC);
    end
    prev_valid = InstrValid & RST;
    prev_pc    = PC;
    prev_instr = Instr;
  end

  task automatic wait_issue();
    for (int i = 0; i < 100 && !InstrValid; i++) @(negedge CLK);
    if (!InstrValid) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got no InstrValid expected 1");
    end
  endtask

  task automatic dir_step(input int nstall, input logic j, input logic b,
                          input logic [31:0] imm, input logic [31:0] want,
                          input int ackdly);
    wait_issue();
    for (int i = 0; i < nstall; i++) begin
      Stall   = 1'b1;
      Jump    = 1'b1;
      PCSrc   = 1'b1;
      SignImm = $urandom;
      @(negedge CLK);
    end
    Stall   = 1'b0;
    Jump    = j;
    PCSrc   = b;
    SignImm = imm;
    advance(j, b, imm);
    IMemAck = (ackdly == 0);
    @(negedge CLK);
    Jump  = 1'b0;
    PCSrc = 1'b0;
    check("dir_pc", PC, want);
    for (int i = 0; i < ackdly; i++) begin
      check("dly_req", {31'd0, IMemReq}, 32'd1);
      check("dly_addr", IMemAddr, want);
      if (i == ackdly - 1) IMemAck = 1'b1;
      @(negedge CLK);
    end
    IMemAck = 1'b1;
  endtask

  task automatic release_reset();
    sbq.delete();
    model_pc = MIPS_RESET_PC;
    sbq.push_back('{model_pc, mem_word(model_pc)});
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("rel_req", {31'd0, IMemReq}, 32'd1);
    check("rel_addr", IMemAddr, MIPS_RESET_PC);
    check("rel_valid", {31'd0, InstrValid}, 32'd0);
    check("rel_instr", Instr, MIPS_NOP_INSTR);
    @(negedge CLK);
  endtask

  task automatic check_reset_outputs();
    check("rst_req", {31'd0, IMemReq}, 32'd0);
    check("rst_valid", {31'd0, InstrValid}, 32'd0);
    check("rst_pc", PC, MIPS_RESET_PC);
    check("rst_instr", Instr, MIPS_NOP_INSTR);
  endtask

  initial begin
    int idle;
    #12;
    check_reset_outputs();
    @(negedge CLK);
    IMemAck = 1'b1;
    release_reset();

    dir_step(0, 1'b0, 1'b0, 32'h0, 32'h0000_0004, 0);
    dir_step(0, 1'b0, 1'b1, 32'h2, 32'h0000_0010, 0);
    dir_step(3, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_000C, 0);
    dir_step(0, 1'b0, 1'b1, 32'h4, 32'h0000_0020, 4);
    dir_step(0, 1'b1, 1'b1, 32'h0, 32'h0000_0100, 0);
    dir_step(0, 1'b0, 1'b1, 32'h3FFF_FFBE, 32'hFFFF_FFFC, 0);
    dir_step(0, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 0);

    IMemAck = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    check_reset_outputs();
    IMemAck = 1'b1;
    @(negedge CLK);
    release_reset();

    idle = 0;
    for (int n = 0; n < 600; n++) begin
      IMemAck = ($urandom % 3) == 0;
      junk    = $urandom;
      if (InstrValid) begin
        idle    = 0;
        Stall   = ($urandom % 4) == 0;
        Jump    = ($urandom % 5) == 0;
        PCSrc   = ($urandom % 2) == 0;
        SignImm = 32'($urandom_range(0, 64)) - 32'd32;
        if (!Stall) advance(Jump, PCSrc, SignImm);
      end else begin
        idle++;
        Stall   = $urandom % 2;
        Jump    = $urandom % 2;
        PCSrc   = $urandom % 2;
        SignImm = $urandom;
        if (idle > 60) begin
          checks++;
          errors++;
          $display("FAIL rand_timeout: got no issue expected issue");
          break;
        end
      end
      @(negedge CLK);
    end

    Stall   = 1'b1;
    IMemAck = 1'b1;
    wait_issue();
    @(negedge CLK);
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
